// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants and FSM state encoding for the BCD blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int          BCD_NIBBLE_W  = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_conv = 2'd1;
    localparam state_t c_st_done = 2'd2;

endpackage

`default_nettype wire

// File: rtl/bcd_mac10.sv
// ============================================================================
// Module      : bcd_mac10
// Description : Combinational acc*10 + digit step with invalid-digit flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]        i_acc,
    input  logic [BCD_NIBBLE_W-1:0] i_digit,
    output logic [BIN_W-1:0]        o_result,
    output logic                    o_digit_invalid
);

    localparam int c_wide_w = BIN_W + 4;

    logic [c_wide_w-1:0] w_acc_ext;

    assign w_acc_ext = {4'd0, i_acc};

    // Multiply by ten as two shifts so no multiplier is inferred; top bits drop.
    assign o_result = BIN_W'((w_acc_ext << 3) + (w_acc_ext << 1) + c_wide_w'(i_digit));

    assign o_digit_invalid = (i_digit > BCD_MAX_DIGIT);

endmodule

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Iterative packed-BCD to binary converter, one digit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DIGITS-1:0]     bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    err
);

    localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  r_state;
    logic [4*DIGITS-1:0]     r_shift;
    logic [BIN_W-1:0]        r_acc;
    logic [BIN_W-1:0]        r_bin;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_err;

    logic [BCD_NIBBLE_W-1:0] w_digit;
    logic [BIN_W-1:0]        w_next_acc;
    logic                    w_invalid;

    assign w_digit = r_shift[4*DIGITS-1 -: BCD_NIBBLE_W];

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac10 (
        .i_acc           (r_acc),
        .i_digit         (w_digit),
        .o_result        (w_next_acc),
        .o_digit_invalid (w_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_shift <= '0;
            r_acc   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_err   <= 1'b0;
                        r_cnt   <= c_cnt_w'(DIGITS - 1);
                        r_state <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    r_acc   <= w_next_acc;
                    r_shift <= r_shift << BCD_NIBBLE_W;
                    r_err   <= r_err | w_invalid;
                    if (r_cnt == '0) begin
                        // A bad digit anywhere invalidates the whole value.
                        r_bin   <= (r_err | w_invalid) ? '0 : w_next_acc;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign bin_out   = r_bin;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// Module      : tb_bcd_to_bin_seq
// Description : Scoreboard bench for the sequential BCD to binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin_out;
    logic        err;

    int          checks;
    int          errors;
    logic [14:0] exp_q[$];

    bcd_to_bin_seq #(
        .DIGITS (4),
        .BIN_W  (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {err, value} using positional weights.
    function automatic logic [14:0] model(input logic [15:0] w);
        int v;
        int d;
        int p;
        bit e;
        v = 0;
        p = 1;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (w >> (4 * i)) & 15;
            if (d > 9) e = 1'b1;
            v = v + d * p;
            p = p * 10;
        end
        if (e) return {1'b1, 14'd0};
        return {1'b0, v[13:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [15:0] w, output bit ok);
        bcd_in   = w;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (ok) exp_q.push_back(model(w));
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = 16'h0000;
        rst_n     = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got ov=%b bin=%0d err=%b rdy=%b exp ov=0 bin=0 err=0 rdy=1",
                     out_valid, bin_out, err, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_out_ready got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_convert(input logic [15:0] w);
        bit          ok;
        int          cyc;
        logic [14:0] exp;
        out_ready = 1'b1;
        accept_word(w, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_%h got no_accept exp accept", w);
            return;
        end
        wait_out(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL latency_%h got %0d exp 4", w, cyc);
        end
        if (!out_valid) return;
        exp = exp_q.pop_front();
        checks++;
        if (bin_out !== exp[13:0] || err !== exp[14]) begin
            errors++;
            $display("FAIL result_%h got bin=%0d err=%b exp bin=%0d err=%b",
                     w, bin_out, err, exp[13:0], exp[14]);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_%h got ov=%b exp ov=0", w, out_valid);
        end
    endtask

    task automatic test_basic();
        test_convert(16'h1234);
        test_convert(16'h9999);
        test_convert(16'h0000);
    endtask

    task automatic test_error();
        test_convert(16'h12A4);
        test_convert(16'h0042);
        test_convert(16'hF000);
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          cyc;
        logic [14:0] exp;
        out_ready = 1'b0;
        accept_word(16'h0500, ok);
        wait_out(cyc);
        checks++;
        if (!out_valid || cyc != 4) begin
            errors++;
            $display("FAIL bp_latency got ov=%b cyc=%0d exp ov=1 cyc=4", out_valid, cyc);
        end
        exp      = exp_q.pop_front();
        bcd_in   = 16'h0003;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || bin_out !== exp[13:0] || err !== exp[14] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got ov=%b bin=%0d err=%b rdy=%b exp ov=1 bin=%0d err=%b rdy=0",
                         out_valid, bin_out, err, in_ready, exp[13:0], exp[14]);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept got rdy=%b exp rdy=0", in_ready);
        end
        exp_q.push_back(model(16'h0003));
        wait_out(cyc);
        checks++;
        if (!out_valid || exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_next_timeout got ov=%b exp ov=1", out_valid);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (bin_out !== exp[13:0] || err !== exp[14] || cyc != 4) begin
                errors++;
                $display("FAIL bp_next_result got bin=%0d err=%b cyc=%0d exp bin=%0d err=%b cyc=4",
                         bin_out, err, cyc, exp[13:0], exp[14]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        bcd_in    = 16'h7777;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy got rdy=%b exp rdy=0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset got ov=%b bin=%0d err=%b rdy=%b exp ov=0 bin=0 err=0 rdy=1",
                     out_valid, bin_out, err, in_ready);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_result got pulses=%0d rdy=%b exp pulses=0 rdy=1", seen, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3];
        int          idx;
        int          got;
        int          last;
        bit          acc;
        logic [14:0] exp;
        words[0]  = 16'h0001;
        words[1]  = 16'h0010;
        words[2]  = 16'h0100;
        idx       = 0;
        got       = 0;
        last      = -1;
        out_ready = 1'b1;
        bcd_in    = words[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 100 && got < 3; c++) begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got bin=%0d exp none", bin_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (bin_out !== exp[13:0] || err !== exp[14]) begin
                        errors++;
                        $display("FAIL stream_result got bin=%0d err=%b exp bin=%0d err=%b",
                                 bin_out, err, exp[13:0], exp[14]);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 6) begin
                        errors++;
                        $display("FAIL stream_interval got %0d exp 6", c - last);
                    end
                end
                last = c;
                got++;
            end
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                exp_q.push_back(model(words[idx]));
                idx++;
                if (idx < 3) bcd_in = words[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count got %0d left=%0d exp 3 left=0", got, exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
